// File: rtl/ks_accum_pkg.sv
// ---------------------------------------------------------------------------
// ks_accum_pkg
// Shared definitions for the ks_stream_accum reduction stage: FSM state
// encoding and default width parameters.
// Optional build macro used by the block: KS_ACCUM_SATURATE_EN.
// ---------------------------------------------------------------------------
package ks_accum_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/kogge.sv
// ---------------------------------------------------------------------------
// kogge
// Parameterised Kogge-Stone parallel-prefix adder, purely combinational.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry in
//   s     out WIDTH  sum
//   cout  out 1      carry out of the MSB
// ---------------------------------------------------------------------------
module kogge #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] gc, pc, gn, pn;
  logic [WIDTH:0]   carry;

  always_comb begin
    gc    = a & b;
    pc    = a ^ b;
    gn    = '0;
    pn    = '0;
    // log2(WIDTH) prefix levels; span doubles each level.
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = gc;
      pn = pc;
      for (int i = d; i < WIDTH; i++) begin
        gn[i] = gc[i] | (pc[i] & gc[i-d]);
        pn[i] = pc[i] & pc[i-d];
      end
      gc = gn;
      pc = pn;
    end
    // gc/pc now hold group generate/propagate over bits [i:0].
    carry = {gc | (pc & {WIDTH{cin}}), cin};
    s     = (a ^ b) ^ carry[WIDTH-1:0];
    cout  = carry[WIDTH];
  end

endmodule

// File: rtl/ks_stream_accum.sv
// ---------------------------------------------------------------------------
// ks_stream_accum
// Streaming multi-operand accumulator built on the kogge adder. A start
// pulse in IDLE latches a run length; that many unsigned operands are summed
// from the in_valid/in_ready stream and the result is held on the
// out_valid/out_ready port until taken.
//
// Build option: KS_ACCUM_SATURATE_EN - clamp the accumulator to all-ones on
// carry out instead of wrapping modulo 2^ACC_W.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      begin a run (honoured in IDLE only)
//   len        in   LEN_W  operands in the run, latched with start
//   in_valid   in   1      operand valid
//   in_data    in   WIDTH  unsigned operand
//   in_ready   out  1      operand accepted this cycle when valid
//   out_valid  out  1      result valid
//   out_ready  in   1      result consumed
//   out_sum    out  ACC_W  accumulated sum (zero outside DONE)
//   out_ovf    out  1      carry out of ACC_W seen during the run
//   busy       out  1      not IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// ACCUM | accepting operands; remaining counts down to the last one
// DONE  | result presented until out_ready
// ---------------------------------------------------------------------------
module ks_stream_accum
  import ks_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] add_b, add_s, acc_add;
  logic             add_cout;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             ovf, ovf_nxt;

  // ACC_W >= WIDTH, so this cast is a plain zero-extension.
  assign add_b = ACC_W'(in_data);

  kogge #(ACC_W) u_kogge (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

`ifdef KS_ACCUM_SATURATE_EN
  // Once clamped, every later non-zero add carries again, so acc stays
  // at all-ones for the remainder of the run.
  assign acc_add = add_cout ? '1 : add_s;
`else
  assign acc_add = add_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          remaining_nxt = len;
          state_nxt     = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt       = acc_add;
          ovf_nxt       = ovf | add_cout;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // acc and ovf are registers; they are only exposed while the result is up.
  assign out_sum   = out_valid ? acc : '0;
  assign out_ovf   = out_valid & ovf;

endmodule

// File: tb/tb_ks_stream_accum.sv
// ---------------------------------------------------------------------------
// tb_ks_stream_accum
// Two instances share every input: dut_a at default widths (ACC_W=16) and
// dut_b with ACC_W=8 so that carry out is reachable. Expected results come
// from the plain integer total of each run.
// ---------------------------------------------------------------------------
module tb_ks_stream_accum;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len, in_data;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [15:0] out_sum_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [7:0]  out_sum_b;

  int n_assert = 0;
  int n_fail   = 0;
  int ops[$];

  always #5 clk = ~clk;

  ks_stream_accum #(.WIDTH(8), .ACC_W(16), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  ks_stream_accum #(.WIDTH(8), .ACC_W(8), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: result of summing a run of operands into a w-bit register.
  function automatic logic [31:0] model_sum(input int total, input int w);
    int lim;
    lim = 1 << w;
    if (total < lim) return 32'(total);
`ifdef KS_ACCUM_SATURATE_EN
    return 32'(lim - 1);
`else
    return 32'(total % lim);
`endif
  endfunction

  function automatic logic [31:0] model_ovf(input int total, input int w);
    return (total >= (1 << w)) ? 32'd1 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready_a"},  32'(in_ready_a),  0);
    check({tag, "_out_valid_a"}, 32'(out_valid_a), 0);
    check({tag, "_out_sum_a"},   32'(out_sum_a),   0);
    check({tag, "_out_ovf_a"},   32'(out_ovf_a),   0);
    check({tag, "_busy_a"},      32'(busy_a),      0);
    check({tag, "_out_valid_b"}, 32'(out_valid_b), 0);
    check({tag, "_out_sum_b"},   32'(out_sum_b),   0);
    check({tag, "_busy_b"},      32'(busy_b),      0);
  endtask

  task automatic check_result(input string tag, input int total);
    check({tag, "_out_valid_a"}, 32'(out_valid_a), 1);
    check({tag, "_in_ready_a"},  32'(in_ready_a),  0);
    check({tag, "_busy_a"},      32'(busy_a),      1);
    check({tag, "_out_sum_a"},   32'(out_sum_a),   model_sum(total, 16));
    check({tag, "_out_ovf_a"},   32'(out_ovf_a),   model_ovf(total, 16));
    check({tag, "_out_valid_b"}, 32'(out_valid_b), 1);
    check({tag, "_in_ready_b"},  32'(in_ready_b),  0);
    check({tag, "_out_sum_b"},   32'(out_sum_b),   model_sum(total, 8));
    check({tag, "_out_ovf_b"},   32'(out_ovf_b),   model_ovf(total, 8));
  endtask

  // Runs the operands in ops[]: up to gap_hi idle cycles before each
  // operand after the first, hold cycles of out_ready=0 in DONE, then
  // release. Stray start pulses are thrown in where they must be ignored.
  task automatic run(input string tag, input int gap_hi, input int hold,
                     input bit start_on_release);
    int total;
    int gaps;
    total = 0;
    foreach (ops[i]) total += ops[i];
    start = 1'b1;
    len   = 8'(ops.size());
    tick();
    start = 1'b0;
    for (int i = 0; i < ops.size(); i++) begin
      gaps = (i == 0) ? 0 : $urandom_range(gap_hi, 0);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        start    = 1'($urandom_range(1, 0));
        len      = 8'($urandom);
        check({tag, "_gap_in_ready_a"}, 32'(in_ready_a), 1);
        check({tag, "_gap_in_ready_b"}, 32'(in_ready_b), 1);
        tick();
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'(ops[i]);
      check({tag, "_xfer_in_ready_a"}, 32'(in_ready_a), 1);
      check({tag, "_xfer_out_valid_a"}, 32'(out_valid_a), 0);
      check({tag, "_xfer_out_sum_a"},   32'(out_sum_a),   0);
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    check_result({tag, "_done"}, total);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(1, 0));
      len       = 8'($urandom_range(3, 0));
      in_valid  = 1'($urandom_range(1, 0));
      tick();
      check_result({tag, "_hold"}, total);
    end
    in_valid  = 1'b0;
    start     = start_on_release;
    len       = 8'd5;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check_idle({tag, "_release"});
    if (start_on_release) begin
      tick();
      check_idle({tag, "_after_release"});
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    ops = '{7, 29, 5};
    run("basic", 0, 0, 1'b0);

    ops = '{15, 15};
    run("gaps", 3, 4, 1'b0);

    ops = '{255, 255};
    run("ovf", 0, 1, 1'b0);

    ops.delete();
    run("zero_len", 0, 2, 1'b0);

    ops = '{3};
    run("start_vs_release", 0, 0, 1'b1);

    // Abort a run with reset after two operands.
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd8;
    tick();
    in_data  = 8'd5;
    tick();
    in_valid = 1'b0;
    check("midrun_busy_a", 32'(busy_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrun_reset");
    ops = '{9};
    run("after_reset", 0, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      ops.delete();
      for (int k = $urandom_range(12, 1); k > 0; k--) ops.push_back(int'($urandom_range(255, 0)));
      run("random", 2, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
    end

    ops.delete();
    for (int k = 0; k < 255; k++) ops.push_back(255);
    run("max_len", 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
